// File: rtl/sa_feeder_if.sv
// rtl/sa_feeder_if.sv - job, operand-beat and array-edge signals of the systolic feeder
interface sa_feeder_if #(
    parameter int N = 32
);
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [N-1:0][7:0]   a_col;
    logic [N-1:0][7:0]   b_row;
    logic [N-1:0][7:0]   sa_a;
    logic [N-1:0][7:0]   sa_b;
    logic                sa_clr;
    logic                busy;
    logic                done;
    logic [15:0]         k_cnt;

    modport master (
        output start, in_valid, in_last, a_col, b_row,
        input  in_ready, sa_a, sa_b, sa_clr, busy, done, k_cnt
    );

    modport slave (
        input  start, in_valid, in_last, a_col, b_row,
        output in_ready, sa_a, sa_b, sa_clr, busy, done, k_cnt
    );
endinterface

// File: rtl/sa_feeder.sv
// rtl/sa_feeder.sv - skews A columns / B rows into an NxN systolic array and sequences one job
module sa_feeder #(
    parameter int N     = 32,
    parameter int FLUSH = 2*N-1
) (
    input  logic         clk,
    input  logic         rst,
    sa_feeder_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH - 1);

    state_t      state_q, state_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] k_q, k_d;
    logic        accept;
    logic        clr;

    logic [N-1:0][7:0] sa_a_w;
    logic [N-1:0][7:0] sa_b_w;

    assign bus.in_ready = (state_q == S_STREAM);
    assign accept       = bus.in_valid && (state_q == S_STREAM);
    assign clr          = (state_q == S_CLEAR);
    assign bus.sa_clr   = clr;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.k_cnt    = k_q;
    assign bus.sa_a     = sa_a_w;
    assign bus.sa_b     = sa_b_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (accept) begin
                    if (k_q != 16'hFFFF) k_d = k_q + 16'd1;
                    if (bus.in_last) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                    end
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 16'd0) state_d = S_DONE;
                else                 fcnt_d  = fcnt_q - 16'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lane i is an (i+1)-deep byte chain; unaccepted cycles shift in zeros.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] a_q [0:i];
        logic [7:0] b_q [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst || clr) begin
                for (int s = 0; s <= i; s++) begin
                    a_q[s] <= 8'h00;
                    b_q[s] <= 8'h00;
                end
            end else begin
                a_q[0] <= accept ? bus.a_col[i] : 8'h00;
                b_q[0] <= accept ? bus.b_row[i] : 8'h00;
                for (int s = 1; s <= i; s++) begin
                    a_q[s] <= a_q[s-1];
                    b_q[s] <= b_q[s-1];
                end
            end
        end

        assign sa_a_w[i] = a_q[i];
        assign sa_b_w[i] = b_q[i];
    end
endmodule

// File: tb/tb_sa_feeder.sv
// tb/tb_sa_feeder.sv - directed jobs with a scoreboard-driven monitor for sa_feeder
module tb_sa_feeder;
    localparam int N     = 4;
    localparam int FLUSH = 2*N-1;

    typedef struct {
        bit          valid;
        bit          last;
        bit          start;
        logic [31:0] a;
        logic [31:0] b;
    } slot_t;

    typedef struct {
        int          cyc;
        logic [15:0] k;
    } done_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    logic        exp_ready, exp_busy, exp_clr;
    logic [15:0] exp_k;
    logic [31:0] hist_a [int];
    logic [31:0] hist_b [int];
    done_t       done_q [$];
    slot_t       slots  [$];

    sa_feeder_if #(.N(N)) bus ();

    sa_feeder #(.N(N), .FLUSH(FLUSH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: lane model from accepted-beat history, done popped from the scoreboard.
    initial begin
        logic [31:0] ea, eb, t;
        done_t       e;
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                for (int i = 0; i < N; i++) begin
                    t = hist_a.exists(cyc - i) ? hist_a[cyc - i] : 32'h0;
                    ea[i*8 +: 8] = t[i*8 +: 8];
                    t = hist_b.exists(cyc - i) ? hist_b[cyc - i] : 32'h0;
                    eb[i*8 +: 8] = t[i*8 +: 8];
                end
                chk("sa_a", bus.sa_a, ea);
                chk("sa_b", bus.sa_b, eb);
                chk("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_ready});
                chk("busy", {31'h0, bus.busy}, {31'h0, exp_busy});
                chk("sa_clr", {31'h0, bus.sa_clr}, {31'h0, exp_clr});
                chk("k_cnt", {16'h0, bus.k_cnt}, {16'h0, exp_k});
                if (bus.done) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
                    end else begin
                        e = done_q.pop_front();
                        chk("done_cyc", cyc, e.cyc);
                        chk("done_k", {16'h0, bus.k_cnt}, {16'h0, e.k});
                    end
                end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL done_missing cyc=%0d got=0 exp=1 at %0d", cyc, done_q[0].cyc);
                    void'(done_q.pop_front());
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_sa_a"}, bus.sa_a, 32'h0);
        chk({tag, "_sa_b"}, bus.sa_b, 32'h0);
        chk({tag, "_in_ready"}, {31'h0, bus.in_ready}, 32'h0);
        chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, bus.done}, 32'h0);
        chk({tag, "_sa_clr"}, {31'h0, bus.sa_clr}, 32'h0);
        chk({tag, "_k_cnt"}, {16'h0, bus.k_cnt}, 32'h0);
    endtask

    task automatic run_job(input bit poke_flush, input bit abort);
        logic [15:0] k_next;
        bus.start    = 1'b1;
        bus.in_valid = 1'b0;
        step();
        bus.start = 1'b0;
        exp_busy  = 1'b1;
        exp_clr   = 1'b1;
        step();
        exp_clr   = 1'b0;
        exp_ready = 1'b1;
        exp_k     = 16'h0;
        foreach (slots[n]) begin
            bus.in_valid = slots[n].valid;
            bus.in_last  = slots[n].last;
            bus.start    = slots[n].start;
            bus.a_col    = slots[n].a;
            bus.b_row    = slots[n].b;
            k_next = exp_k;
            if (slots[n].valid) begin
                hist_a[cyc + 1] = slots[n].a;
                hist_b[cyc + 1] = slots[n].b;
                k_next = (exp_k == 16'hFFFF) ? exp_k : exp_k + 16'd1;
                if (slots[n].last) done_q.push_back('{cyc + 1 + FLUSH, k_next});
            end
            step();
            exp_k     = k_next;
            bus.start = 1'b0;
            if (slots[n].valid && slots[n].last) break;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        exp_ready    = 1'b0;
        for (int f = 0; f < FLUSH; f++) begin
            if (abort && f == 1) begin
                rst = 1'b1;
                #1;
                check_all_zero("async_rst");
                void'(done_q.pop_back());
                hist_a.delete();
                hist_b.delete();
                exp_busy = 1'b0;
                exp_k    = 16'h0;
                step();
                step();
                rst = 1'b0;
                step();
                return;
            end
            if (poke_flush && (f == 1 || f == 2)) begin
                bus.start    = (f == 1);
                bus.in_valid = 1'b1;
                bus.in_last  = 1'b1;
                bus.a_col    = 32'hFFEEDDCC;
                bus.b_row    = 32'h77665544;
            end
            step();
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
        step();
        exp_busy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.a_col    = '0;
        bus.b_row    = '0;
        exp_ready    = 1'b0;
        exp_busy     = 1'b0;
        exp_clr      = 1'b0;
        exp_k        = 16'h0;
        #3;
        check_all_zero("reset");
        step();
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        // Three beats, a_col = {4,3,2,1}*(k+1), b_row all ones
        slots.delete();
        slots.push_back('{1'b1, 1'b0, 1'b0, 32'h04030201, 32'h01010101});
        slots.push_back('{1'b1, 1'b0, 1'b0, 32'h08060402, 32'h01010101});
        slots.push_back('{1'b1, 1'b1, 1'b0, 32'h0C090603, 32'h01010101});
        run_job(1'b0, 1'b0);

        // Valid asserted while idle must not be taken
        bus.in_valid = 1'b1;
        bus.a_col    = 32'hDEADBEEF;
        bus.b_row    = 32'hCAFEF00D;
        step();
        step();
        bus.in_valid = 1'b0;
        step();

        // Two-cycle bubble between beats, junk data on the bus during the bubble
        slots.delete();
        slots.push_back('{1'b1, 1'b0, 1'b0, 32'h11223344, 32'h55667788});
        slots.push_back('{1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A});
        slots.push_back('{1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A});
        slots.push_back('{1'b1, 1'b1, 1'b0, 32'h99AABBCC, 32'hDDEEFF10});
        run_job(1'b0, 1'b0);
        step();

        // K=1 job
        slots.delete();
        slots.push_back('{1'b1, 1'b1, 1'b0, 32'h0F0E0D0C, 32'h03020100});
        run_job(1'b0, 1'b0);
        step();

        // start pulsed in STREAM and FLUSH, valid poked in FLUSH
        slots.delete();
        slots.push_back('{1'b1, 1'b0, 1'b0, 32'h01020304, 32'h10203040});
        slots.push_back('{1'b1, 1'b0, 1'b1, 32'h05060708, 32'h50607080});
        slots.push_back('{1'b1, 1'b1, 1'b0, 32'h090A0B0C, 32'h90A0B0C0});
        run_job(1'b1, 1'b0);
        step();

        // Asynchronous reset in FLUSH while lanes still hold data
        slots.delete();
        slots.push_back('{1'b1, 1'b0, 1'b0, 32'h21222324, 32'h31323334});
        slots.push_back('{1'b1, 1'b1, 1'b0, 32'h41424344, 32'h51525354});
        run_job(1'b0, 1'b1);
        step();
        step();

        // Clean job after the abort
        slots.delete();
        slots.push_back('{1'b1, 1'b0, 1'b0, 32'h04030201, 32'h08070605});
        slots.push_back('{1'b1, 1'b1, 1'b0, 32'h0D0C0B0A, 32'h1A1B1C1D});
        run_job(1'b0, 1'b0);
        step();
        step();
        step();

        chk("done_q_empty", done_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
